perf_counter_reader: RTL and testbench
======================================

PERF_COUNTER_READER -- requirements
Module: perf_counter_reader

Interface
REQ-001 Parameter NUM_CNT, default 8: number of event counters attached.
REQ-002 Parameter CNT_WIDTH, default 16: width of each counter value, 1..32.
REQ-003 Parameter BASE_ADDR, default 32'hFFFF_FF00: word-aligned base of the register window.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 count_vec  input  NUM_CNT*CNT_WIDTH  counter values; counter i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-007 mem_read  input  1  read request, held until mem_resp.
REQ-008 mem_write  input  1  write request, held until mem_resp.
REQ-009 mem_address  input  32  byte address of the request.
REQ-010 mem_wdata  input  32  write data.
REQ-011 mem_rdata  output  32  read data, valid while mem_resp=1.
REQ-012 mem_resp  output  1  one-cycle completion pulse.
REQ-013 cnt_reset  output  NUM_CNT  per-counter clear, drives each counter's reset input.

Function
REQ-014 Register map: offset 4*i (i < NUM_CNT) = counter i; offset 4*NUM_CNT = CTRL; every other offset in window or outside window = unmapped.
REQ-015 FSM states IDLE, EXEC, RESP; IDLE->EXEC when mem_read|mem_write; EXEC->RESP unconditionally; RESP->IDLE unconditionally.
REQ-016 In IDLE with a request present, address, wdata and read/write type latch; later changes on those inputs are ignored until IDLE.
REQ-017 mem_read and mem_write both high: treated as a read; write is discarded.
REQ-018 Counter read: in EXEC the selected counter value is zero-extended to 32 bits and registered into mem_rdata.
REQ-019 CTRL read returns {8'h00, CNT_WIDTH[7:0], 8'h00, NUM_CNT[7:0]}.
REQ-020 Unmapped read returns 32'h0; unmapped write has no effect; both still complete with mem_resp.
REQ-021 Counter-i write, any data: cnt_reset[i]=1 for exactly the EXEC->RESP cycle (one cycle); other bits 0.
REQ-022 CTRL write with mem_wdata[0]=1: all cnt_reset bits high for one cycle; mem_wdata[0]=0: no effect.
REQ-023 mem_resp=1 only in RESP, exactly 2 cycles after the accepting edge; mem_rdata held stable in RESP, 0 otherwise.
REQ-024 Requestor drops the request the cycle after mem_resp; a request still high in IDLE is a new request (back-to-back allowed, 3-cycle throughput).
REQ-025 Counter value is sampled once in EXEC; increments after that sample are not reflected in the same response.

Reset
REQ-026 reset asserted, any state: FSM->IDLE, mem_resp=0, mem_rdata=0, latched request cleared, cnt_reset=all ones.
REQ-027 cnt_reset returns to all zeros on the first rising edge after reset deasserts.
REQ-028 A request in flight at reset is abandoned with no mem_resp; requestor must reissue.

Structure
REQ-029 Package perf_pkg holds state enum (IDLE, EXEC, RESP), CTRL offset function of NUM_CNT, and CTRL bit index constant CLR_ALL=0.
REQ-030 One sub-module perf_addr_decode: combinational window/offset decode giving hit, is_ctrl, counter index.
REQ-031 No other sub-modules; counters themselves remain outside this block.

Verification
REQ-032 Reset release: cnt_reset=8'hFF during reset, 8'h00 one edge after; mem_resp=0 throughout.
REQ-033 count_vec counter 3 = 16'h1234, read BASE+12 -> mem_resp 2 cycles after accept, mem_rdata=32'h0000_1234.
REQ-034 Write BASE+8, data 32'hDEAD -> cnt_reset=8'h04 for one cycle, then mem_resp; no other bit toggles.
REQ-035 Write CTRL (BASE+32) data 1 -> cnt_reset=8'hFF one cycle; read CTRL -> 32'h0010_0008.
REQ-036 Read BASE+64 and address 32'h0000_1000 -> mem_rdata=0, mem_resp pulses; mem_read+mem_write together at BASE+4 -> read result, cnt_reset stays 0.
REQ-037 Reset asserted in EXEC of a counter-1 write -> no mem_resp, FSM IDLE, cnt_reset all ones until release.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter register reader.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit of the CTRL write data that clears every attached counter.
    localparam int CLR_ALL = 0;

    // Byte offset of CTRL: it sits directly after the last counter word.
    function automatic logic [31:0] ctrl_offset(input int num_cnt);
        return 32'(4 * num_cnt);
    endfunction

endpackage

// File: rtl/perf_addr_decode.sv
// Window decode: maps a byte address onto a counter index or the CTRL word.
// Anything outside the window, past CTRL, or not word-aligned is unmapped.
module perf_addr_decode
    import perf_pkg::*;
#(
    parameter int          NUM_CNT   = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          IDX_W     = 3
) (
    input  logic [31:0]      address,
    output logic             hit,
    output logic             is_ctrl,
    output logic [IDX_W-1:0] index
);

    logic [31:0] offset;

    // Addresses below the base wrap to a huge offset and fall out as unmapped.
    assign offset = address - BASE_ADDR;

    // Classify the offset against the counter words and the CTRL word.
    always_comb begin
        hit     = (offset[1:0] == 2'b00) && (offset <= ctrl_offset(NUM_CNT));
        is_ctrl = (offset == ctrl_offset(NUM_CNT));
        index   = offset[IDX_W+1:2];
    end

endmodule

// File: rtl/perf_counter_reader.sv
// Memory-mapped reader for a bank of external event counters, with per-counter
// and global clear through cnt_reset.
//
//  state | meaning
//  IDLE  | waiting for mem_read/mem_write; latches address and type on accept
//  EXEC  | samples the selected counter / CTRL word; cnt_reset pulse is visible
//  RESP  | mem_resp high, mem_rdata held
module perf_counter_reader
    import perf_pkg::*;
#(
    parameter int          NUM_CNT   = 8,
    parameter int          CNT_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CNT*CNT_WIDTH-1:0]   count_vec,
    input  logic                           mem_read,
    input  logic                           mem_write,
    input  logic [31:0]                    mem_address,
    input  logic [31:0]                    mem_wdata,
    output logic [31:0]                    mem_rdata,
    output logic                           mem_resp,
    output logic [NUM_CNT-1:0]             cnt_reset
);

    localparam int IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    state_t           state;
    logic [31:0]      addr_q;
    logic             is_write_q;

    logic [31:0]      dec_addr;
    logic             dec_hit;
    logic             dec_ctrl;
    logic [IDX_W-1:0] dec_index;

    logic             req;
    logic             wr_req;
    logic [31:0]      cnt_val;
    logic [31:0]      rd_val;
    logic [NUM_CNT-1:0] clr_vec;
    logic [31:0]      ctrl_word;

    // Only the CLR_ALL bit of the write data carries meaning.
    logic             unused_wdata;
    assign unused_wdata = ^{mem_wdata[31:CLR_ALL+1], 1'b0};

    // Decode the live address while accepting, the latched one afterwards.
    assign dec_addr = (state == IDLE) ? mem_address : addr_q;

    perf_addr_decode #(
        .NUM_CNT   (NUM_CNT),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_decode (
        .address (dec_addr),
        .hit     (dec_hit),
        .is_ctrl (dec_ctrl),
        .index   (dec_index)
    );

    // A simultaneous read and write is served as a read.
    assign req       = mem_read | mem_write;
    assign wr_req    = mem_write & ~mem_read;
    assign ctrl_word = {8'h00, 8'(CNT_WIDTH), 8'h00, 8'(NUM_CNT)};

    // Select and zero-extend the addressed counter, or the CTRL word.
    always_comb begin
        cnt_val = '0;
        if (dec_hit && !dec_ctrl) begin
            cnt_val[CNT_WIDTH-1:0] = count_vec[dec_index*CNT_WIDTH +: CNT_WIDTH];
        end
        rd_val = dec_ctrl ? ctrl_word : cnt_val;
    end

    // Clear pattern produced by a write to the decoded address.
    always_comb begin
        clr_vec = '0;
        if (dec_hit && !dec_ctrl) begin
            clr_vec[dec_index] = 1'b1;
        end else if (dec_ctrl && mem_wdata[CLR_ALL]) begin
            clr_vec = '1;
        end
    end

    // Request sequencer; cnt_reset is held high throughout reset so the
    // external counters stay cleared until the block is running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            mem_resp   <= 1'b0;
            mem_rdata  <= '0;
            cnt_reset  <= '1;
        end else begin
            cnt_reset <= '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q     <= mem_address;
                        is_write_q <= wr_req;
                        if (wr_req) begin
                            cnt_reset <= clr_vec;
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    mem_rdata <= is_write_q ? 32'h0 : rd_val;
                    mem_resp  <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    mem_resp   <= 1'b0;
                    mem_rdata  <= '0;
                    is_write_q <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    mem_resp  <= 1'b0;
                    mem_rdata <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed bench for perf_counter_reader with default parameters.
module tb_perf_counter_reader;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic         clk;
    logic         reset;
    logic [127:0] count_vec;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [7:0]   cnt_reset;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic [7:0]  cr_exec;
    logic [7:0]  cr_resp;
    int          lat;

    perf_counter_reader #(
        .NUM_CNT   (8),
        .CNT_WIDTH (16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count_vec   (count_vec),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .cnt_reset   (cnt_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge; the address/data are scrambled once
    // the request has been accepted to show the latched copy is used.
    task automatic do_req(input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic [7:0] cre, output logic [7:0] crr, output int l);
        mem_read    = r;
        mem_write   = w;
        mem_address = addr;
        mem_wdata   = wdata;
        rdata = '0; cre = '0; crr = '0; l = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cre         = cnt_reset;
                mem_address = BASE + 32'd32;
                mem_wdata   = 32'h1;
            end
            if (mem_resp) begin
                l     = c;
                rdata = mem_rdata;
                crr   = cnt_reset;
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("idle_resp", {31'b0, mem_resp}, 32'h0);
        chk("idle_rdata", mem_rdata, 32'h0);
        chk("idle_cnt_reset", {24'b0, cnt_reset}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        count_vec   = '0;
        count_vec[0*16 +: 16] = 16'h0101;
        count_vec[1*16 +: 16] = 16'hBEEF;
        count_vec[2*16 +: 16] = 16'h2222;
        count_vec[3*16 +: 16] = 16'h1234;
        count_vec[4*16 +: 16] = 16'h4444;
        count_vec[5*16 +: 16] = 16'h5555;
        count_vec[6*16 +: 16] = 16'h6666;
        count_vec[7*16 +: 16] = 16'hFFFF;

        repeat (2) @(negedge clk);
        chk("rst_cnt_reset", {24'b0, cnt_reset}, 32'hFF);
        chk("rst_resp", {31'b0, mem_resp}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        reset = 1'b0;
        #1;
        chk("rel_before_edge", {24'b0, cnt_reset}, 32'hFF);
        @(negedge clk);
        chk("rel_after_edge", {24'b0, cnt_reset}, 32'h0);
        chk("rel_resp", {31'b0, mem_resp}, 32'h0);

        do_req(1'b1, 1'b0, BASE + 32'd12, 32'h0, rd, cr_exec, cr_resp, lat);
        chk("rd_c3_lat", 32'(lat), 32'd2);
        chk("rd_c3_data", rd, 32'h0000_1234);
        chk("rd_c3_clr", {24'b0, cr_exec}, 32'h0);

        do_req(1'b0, 1'b1, BASE + 32'd8, 32'hDEAD, rd, cr_exec, cr_resp, lat);
        chk("wr_c2_lat", 32'(lat), 32'd2);
        chk("wr_c2_clr_exec", {24'b0, cr_exec}, 32'h04);
        chk("wr_c2_clr_resp", {24'b0, cr_resp}, 32'h0);
        chk("wr_c2_rdata", rd, 32'h0);

        do_req(1'b0, 1'b1, BASE + 32'd32, 32'h1, rd, cr_exec, cr_resp, lat);
        chk("wr_ctrl_lat", 32'(lat), 32'd2);
        chk("wr_ctrl_clr_exec", {24'b0, cr_exec}, 32'hFF);
        chk("wr_ctrl_clr_resp", {24'b0, cr_resp}, 32'h0);

        do_req(1'b1, 1'b0, BASE + 32'd32, 32'h0, rd, cr_exec, cr_resp, lat);
        chk("rd_ctrl_data", rd, 32'h0010_0008);

        do_req(1'b1, 1'b0, BASE + 32'd64, 32'h0, rd, cr_exec, cr_resp, lat);
        chk("rd_unmap_win_lat", 32'(lat), 32'd2);
        chk("rd_unmap_win_data", rd, 32'h0);

        do_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, rd, cr_exec, cr_resp, lat);
        chk("rd_unmap_out_lat", 32'(lat), 32'd2);
        chk("rd_unmap_out_data", rd, 32'h0);

        do_req(1'b1, 1'b1, BASE + 32'd4, 32'hFFFF_FFFF, rd, cr_exec, cr_resp, lat);
        chk("rdwr_c1_data", rd, 32'h0000_BEEF);
        chk("rdwr_c1_clr_exec", {24'b0, cr_exec}, 32'h0);
        chk("rdwr_c1_clr_resp", {24'b0, cr_resp}, 32'h0);

        do_req(1'b1, 1'b0, BASE + 32'd28, 32'h0, rd, cr_exec, cr_resp, lat);
        chk("rd_c7_data", rd, 32'h0000_FFFF);

        do_req(1'b0, 1'b1, BASE + 32'd32, 32'h2, rd, cr_exec, cr_resp, lat);
        chk("wr_ctrl0_clr", {24'b0, cr_exec}, 32'h0);
        chk("wr_ctrl0_lat", 32'(lat), 32'd2);

        do_req(1'b0, 1'b1, BASE + 32'd36, 32'h1, rd, cr_exec, cr_resp, lat);
        chk("wr_unmap_clr", {24'b0, cr_exec}, 32'h0);
        chk("wr_unmap_lat", 32'(lat), 32'd2);

        do_req(1'b1, 1'b0, BASE + 32'd2, 32'h0, rd, cr_exec, cr_resp, lat);
        chk("rd_misalign_data", rd, 32'h0);

        do_req(1'b0, 1'b1, BASE, 32'h0, rd, cr_exec, cr_resp, lat);
        chk("wr_c0_clr_exec", {24'b0, cr_exec}, 32'h01);

        // Reset while a counter-1 write is in EXEC.
        mem_write   = 1'b1;
        mem_address = BASE + 32'd4;
        mem_wdata   = 32'h0;
        @(negedge clk);
        chk("abort_exec_clr", {24'b0, cnt_reset}, 32'h02);
        reset = 1'b1;
        #1;
        chk("abort_clr_all", {24'b0, cnt_reset}, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_resp", {31'b0, mem_resp}, 32'h0);
            chk("abort_clr_hold", {24'b0, cnt_reset}, 32'hFF);
        end
        mem_write = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        chk("abort_rel_clr", {24'b0, cnt_reset}, 32'h0);
        chk("abort_rel_resp", {31'b0, mem_resp}, 32'h0);

        do_req(1'b1, 1'b0, BASE + 32'd4, 32'h0, rd, cr_exec, cr_resp, lat);
        chk("post_abort_lat", 32'(lat), 32'd2);
        chk("post_abort_data", rd, 32'h0000_BEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
